// File: rtl/field_pkg.sv
// Shared types and width helpers for the field packer/unpacker family.
package field_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Bits needed to hold a field count in the range 0..fields.
  function automatic int count_w(input int fields);
    return $clog2(fields + 1);
  endfunction

  // Bits needed to hold a field index 0..fields-1, never narrower than one bit.
  function automatic int index_w(input int fields);
    return (fields > 1) ? $clog2(fields) : 1;
  endfunction

endpackage

// File: rtl/field_select.sv
// Combinational pick of one FIELD_W-wide field out of a packed word; field 0 is the low bits.
module field_select
  import field_pkg::*;
#(
  parameter int FIELD_W = 8,
  parameter int FIELDS  = 4,
  localparam int IW     = index_w(FIELDS)
) (
  input  logic [FIELDS*FIELD_W-1:0] word,
  input  logic [IW-1:0]             index,
  output logic [FIELD_W-1:0]        field
);

  // Explicit mux over legal indices so an out-of-range index reads zero.
  always_comb begin
    field = '0;
    for (int k = 0; k < FIELDS; k++) begin
      if (index == IW'(k)) begin
        field = word[k*FIELD_W +: FIELD_W];
      end
    end
  end

endmodule

// File: rtl/field_unpack_stream.sv
// Streams the fields of one packed word out one per cycle, with valid/ready on both sides.
module field_unpack_stream
  import field_pkg::*;
#(
  parameter int FIELD_W   = 8,
  parameter int FIELDS    = 4,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW       = count_w(FIELDS),
  localparam int IW       = index_w(FIELDS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FIELDS*FIELD_W-1:0] in_data,
  input  logic [CW-1:0]             in_count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FIELD_W-1:0]        out_data,
  output logic [IW-1:0]             out_index,
  output logic                      out_last,
  output state_e                    dbg_state
);

  // Handshake: a transfer happens on a rising clock edge where valid && ready;
  // valid must not depend on ready, and in_ready may depend combinationally on out_ready.

  generate
    if (FIELD_W < 1) begin : g_bad_field_w
      $error("field_unpack_stream: FIELD_W must be >= 1");
    end
    if (FIELDS < 1) begin : g_bad_fields
      $error("field_unpack_stream: FIELDS must be >= 1");
    end
  endgenerate

  state_e                    state_q, state_d;
  logic [FIELDS*FIELD_W-1:0] word_q, word_d;
  logic [CW-1:0]             count_q, count_d;
  logic [IW-1:0]             pos_q, pos_d;
  logic [CW-1:0]             n_eff;
  logic [CW-1:0]             rev_idx;
  logic [IW-1:0]             sel_idx;
  logic [FIELD_W-1:0]        sel_field;
  logic                      emit;
  logic                      accept;

  field_select #(
    .FIELD_W (FIELD_W),
    .FIELDS  (FIELDS)
  ) u_select (
    .word  (word_q),
    .index (sel_idx),
    .field (sel_field)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      count_q <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
      pos_q   <= pos_d;
    end
  end

  // pos_q counts emitted fields; the word index is derived from it and the order.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    pos_d   = pos_q;
    accept  = in_valid && in_ready;
    n_eff   = (in_count > CW'(FIELDS)) ? CW'(FIELDS) : in_count;
    if (emit && out_ready) begin
      if (out_last) begin
        state_d = ST_IDLE;
      end else begin
        pos_d = pos_q + IW'(1);
      end
    end
    // A zero-field word is consumed without ever entering EMIT.
    if (accept && (n_eff != '0)) begin
      word_d  = in_data;
      count_d = n_eff;
      pos_d   = '0;
      state_d = ST_EMIT;
    end
  end

  always_comb begin
    emit      = (state_q == ST_EMIT);
    rev_idx   = count_q - CW'(1) - CW'(pos_q);
    sel_idx   = LSB_FIRST ? pos_q : rev_idx[IW-1:0];
    out_valid = emit;
    out_last  = emit && (CW'(pos_q) == (count_q - CW'(1)));
    out_data  = emit ? sel_field : '0;
    out_index = emit ? sel_idx : '0;
    in_ready  = !emit || (out_ready && out_last);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_field_unpack_stream.sv
// Directed plus short random bench for field_unpack_stream with LSB-first and MSB-first instances.
module tb_field_unpack_stream;
  import field_pkg::*;

  logic        clock;
  logic        reset;

  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [31:0] in_data;
  logic [2:0]  in_count;
  logic [7:0]  out_data;
  logic [1:0]  out_index;
  state_e      dbg_state;

  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_last;
  logic [31:0] m_in_data;
  logic [2:0]  m_in_count;
  logic [7:0]  m_out_data;
  logic [1:0]  m_out_index;
  state_e      m_dbg_state;

  logic [10:0] exp_q[$];
  logic [10:0] m_exp_q[$];
  int checks = 0;
  int errors = 0;

  field_unpack_stream #(.FIELD_W(8), .FIELDS(4), .LSB_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .dbg_state(dbg_state)
  );

  field_unpack_stream #(.FIELD_W(8), .FIELDS(4), .LSB_FIRST(1'b0)) dut_msb (
    .clock(clock), .reset(reset),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data), .in_count(m_in_count),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
    .out_index(m_out_index), .out_last(m_out_last), .dbg_state(m_dbg_state)
  );

  // Clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: expected {last, index, data} sequence for one word.
  function automatic void push_word(input logic [31:0] d, input int c, input bit lsb);
    int n;
    int k;
    logic [10:0] e;
    n = (c > 4) ? 4 : c;
    for (int j = 0; j < n; j++) begin
      k = lsb ? j : (n - 1 - j);
      e = {(j == n - 1), 2'(k), d[k*8 +: 8]};
      if (lsb) exp_q.push_back(e);
      else m_exp_q.push_back(e);
    end
  endfunction

  // Scoreboards
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("lsb_unexpected_output", 32'({out_last, out_index, out_data}), 32'h7ff);
      end else begin
        check("lsb_field", 32'({out_last, out_index, out_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && m_out_valid && m_out_ready) begin
      if (m_exp_q.size() == 0) begin
        check("msb_unexpected_output", 32'({m_out_last, m_out_index, m_out_data}), 32'h7ff);
      end else begin
        check("msb_field", 32'({m_out_last, m_out_index, m_out_data}), 32'(m_exp_q.pop_front()));
      end
    end
  end

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic [31:0] d, input int c);
    in_data  = d;
    in_count = 3'(c);
    in_valid = 1'b1;
    push_word(d, c, 1'b1);
  endtask

  task automatic send(input logic [31:0] d, input int c, input bit rnd);
    int waited;
    waited = 0;
    drive(d, c);
    forever begin
      @(negedge clock);
      if (in_ready) break;
      tick();
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      waited++;
      if (waited > 100) begin
        check("send_timeout_in_ready", 32'(in_ready), 32'd1);
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input bit rnd);
    int waited;
    waited = 0;
    forever begin
      @(negedge clock);
      if (!out_valid && exp_q.size() == 0) break;
      tick();
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      waited++;
      if (waited > 300) break;
    end
    out_ready = 1'b1;
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_count = '0; out_ready = 1'b1;
    m_in_valid = 1'b0; m_in_data = '0; m_in_count = '0; m_out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();

    // Basic: one word, fields on cycles 1-4, in_ready low on 1-3
    drive(32'h44332211, 4);
    @(negedge clock);
    check("basic_accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("basic_out_valid", 32'(out_valid), 32'd1);
      check("basic_in_ready", 32'(in_ready), 32'(k == 3));
      tick();
    end
    @(negedge clock);
    check("basic_idle_after", 32'(out_valid), 32'd0);
    tick();

    // Back-to-back: second word held valid, loads on the last handshake with no gap
    drive(32'h44332211, 4);
    tick();
    drive(32'hDDCCBBAA, 4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("b2b_out_valid", 32'(out_valid), 32'd1);
      check("b2b_in_ready", 32'(in_ready), 32'(k == 3 || k == 7));
      tick();
      if (k == 3) in_valid = 1'b0;
    end
    @(negedge clock);
    check("b2b_idle_after", 32'(out_valid), 32'd0);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // Backpressure: first field held for 3 stalled cycles
    drive(32'h44332211, 4);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'h11);
      check("bp_out_index", 32'(out_index), 32'd0);
      check("bp_out_last", 32'(out_last), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    drain(1'b0);
    tick();

    // Zero count: accepted, no output
    drive(32'hAABBCCDD, 0);
    @(negedge clock);
    check("cnt0_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("cnt0_out_valid", 32'(out_valid), 32'd0);
      check("cnt0_in_ready_after", 32'(in_ready), 32'd1);
      tick();
    end

    // Clamped count and single field
    send(32'h87654321, 7, 1'b0);
    drain(1'b0);
    tick();
    send(32'h000000A5, 1, 1'b0);
    @(negedge clock);
    check("cnt1_out_last", 32'(out_last), 32'd1);
    drain(1'b0);
    tick();

    // MSB-first instance
    m_in_data = 32'h00332211;
    m_in_count = 3'd3;
    m_in_valid = 1'b1;
    push_word(32'h00332211, 3, 1'b0);
    @(negedge clock);
    check("msb_accept_ready", 32'(m_in_ready), 32'd1);
    tick();
    m_in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (!m_out_valid && m_exp_q.size() == 0) break;
      tick();
    end
    check("msb_queue_empty", 32'(m_exp_q.size()), 32'd0);
    check("msb_idle_after", 32'(m_out_valid), 32'd0);
    tick();

    // Reset mid-word: discard 33/44 after 22 is emitted
    drive(32'h44332211, 4);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("postrst_out_valid", 32'(out_valid), 32'd0);
      check("postrst_in_ready", 32'(in_ready), 32'd1);
      tick();
    end

    // Random words, counts and backpressure
    for (int w = 0; w < 12; w++) begin
      send($urandom(), int'($urandom_range(0, 7)), 1'b1);
    end
    drain(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
